// File: rtl/rf_writeback_pkg.sv
// Shared register-file write-side definitions: grant encoding and default widths.
// Widths here must match the register file instance they drive.
package rf_writeback_pkg;

   localparam int RF_ADDR_WIDTH = 5;
   localparam int RF_DATA_WIDTH = 32;

   typedef enum logic {
      GRANT_ALU = 1'b0,
      GRANT_LSU = 1'b1
   } grant_e;

endpackage

// File: rtl/rf_writeback_if.sv
// Result channels, issue port and register-file write port of the writeback stage.
// master = execute/memory/decode side, slave = rf_writeback.
interface rf_writeback_if
   import rf_writeback_pkg::*;
#(
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int DATA_WIDTH = RF_DATA_WIDTH
) ();

   logic                         alu_valid;
   logic                         alu_ready;
   logic [ADDR_WIDTH-1:0]        alu_rd;
   logic [DATA_WIDTH-1:0]        alu_data;
   logic                         lsu_valid;
   logic                         lsu_ready;
   logic [ADDR_WIDTH-1:0]        lsu_rd;
   logic [DATA_WIDTH-1:0]        lsu_data;
   logic                         issue_valid;
   logic [ADDR_WIDTH-1:0]        issue_rd;
   logic                         rf_wen;
   logic [ADDR_WIDTH-1:0]        rf_waddr;
   logic [DATA_WIDTH-1:0]        rf_wdata;
   logic [(1<<ADDR_WIDTH)-1:0]   busy;
   logic                         err;

   modport master (
      output alu_valid, alu_rd, alu_data,
      output lsu_valid, lsu_rd, lsu_data,
      output issue_valid, issue_rd,
      input  alu_ready, lsu_ready,
      input  rf_wen, rf_waddr, rf_wdata, busy, err
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  lsu_valid, lsu_rd, lsu_data,
      input  issue_valid, issue_rd,
      output alu_ready, lsu_ready,
      output rf_wen, rf_waddr, rf_wdata, busy, err
   );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard with sticky error on unexpected commits.
// Latency: busy/err update one edge after issue/commit.
// Backpressure: none, accepts an issue and a commit every cycle.
module rf_scoreboard
   import rf_writeback_pkg::*;
#(
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         issue_vld,
   input  logic [ADDR_WIDTH-1:0]        issue_rd,
   input  logic                         commit_vld,
   input  logic [ADDR_WIDTH-1:0]        commit_rd,
   output logic [(1<<ADDR_WIDTH)-1:0]   busy,
   output logic                         err
);

   localparam int NREG = 1 << ADDR_WIDTH;

   logic [NREG-1:0] busy_q, busy_d;
   logic            err_q, err_d;
   logic            set_hit;

   always_comb begin
      busy_d  = busy_q;
      err_d   = err_q;
      set_hit = issue_vld && (issue_rd != '0);
      if (commit_vld) begin
         busy_d[commit_rd] = 1'b0;
         if (!busy_q[commit_rd] && !(set_hit && (issue_rd == commit_rd)))
            err_d = 1'b1;
      end
      // Set after clear: a same-edge reissue belongs to the newer producer.
      if (set_hit)
         busy_d[issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   assign busy = busy_q;
   assign err  = err_q;

endmodule

// File: rtl/rf_writeback.sv
// Arbitrates ALU/LSU results onto the register-file write port and tracks pending writes.
// Latency: accept at edge N drives rf_wen/waddr/wdata during cycle N+1.
// Backpressure: on a tie the loser sees ready low; grants alternate starting with LSU.
module rf_writeback
   import rf_writeback_pkg::*;
#(
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
   parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
   input  logic          clk,
   input  logic          rst_n,
   rf_writeback_if.slave wb
);

   grant_e                last_grant_q, last_grant_d;
   logic                  rf_wen_q, rf_wen_d;
   logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
   logic                  both_vld, alu_rdy, lsu_rdy, alu_acc, lsu_acc;

   always_comb begin
      both_vld     = wb.alu_valid && wb.lsu_valid;
      alu_rdy      = !both_vld || (last_grant_q == GRANT_LSU);
      lsu_rdy      = !both_vld || (last_grant_q == GRANT_ALU);
      alu_acc      = wb.alu_valid && alu_rdy;
      lsu_acc      = wb.lsu_valid && lsu_rdy;
      last_grant_d = last_grant_q;
      if (both_vld)
         last_grant_d = alu_acc ? GRANT_ALU : GRANT_LSU;
      rf_wen_d   = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      // x0 results are consumed like any other but never reach the port.
      if (lsu_acc) begin
         rf_wen_d   = (wb.lsu_rd != '0);
         rf_waddr_d = wb.lsu_rd;
         rf_wdata_d = wb.lsu_data;
      end else if (alu_acc) begin
         rf_wen_d   = (wb.alu_rd != '0);
         rf_waddr_d = wb.alu_rd;
         rf_wdata_d = wb.alu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant_q <= GRANT_ALU;
         rf_wen_q     <= 1'b0;
         rf_waddr_q   <= '0;
         rf_wdata_q   <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         rf_wen_q     <= rf_wen_d;
         rf_waddr_q   <= rf_waddr_d;
         rf_wdata_q   <= rf_wdata_d;
      end
   end

   rf_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .issue_vld  (wb.issue_valid),
      .issue_rd   (wb.issue_rd),
      .commit_vld (rf_wen_q),
      .commit_rd  (rf_waddr_q),
      .busy       (wb.busy),
      .err        (wb.err)
   );

   assign wb.alu_ready = alu_rdy;
   assign wb.lsu_ready = lsu_rdy;
   assign wb.rf_wen    = rf_wen_q;
   assign wb.rf_waddr  = rf_waddr_q;
   assign wb.rf_wdata  = rf_wdata_q;

endmodule

// File: tb/tb_rf_writeback.sv
// Directed scoreboard bench for rf_writeback: expected commits are queued at
// stimulus time and popped by a negedge monitor whenever rf_wen is seen.
module tb_rf_writeback;
   import rf_writeback_pkg::*;

   localparam int AW = 5;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rf_writeback_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb ();

   rf_writeback #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (wb)
   );

   int checks = 0;
   int errors = 0;
   logic [AW+DW-1:0] exp_q[$];

   // Hand-derived tie sequence: ALU x1..x4 vs LSU x6..x9, LSU wins first.
   bit win_lsu  [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
   bit alu_rdy_e[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
   bit lsu_rdy_e[8] = '{1, 0, 1, 0, 1, 0, 1, 1};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [AW-1:0] rd);
      wb.issue_valid = 1'b1;
      wb.issue_rd    = rd;
      tick;
      wb.issue_valid = 1'b0;
   endtask

   task automatic alu_write(input logic [AW-1:0] rd, input logic [DW-1:0] data);
      wb.alu_valid = 1'b1;
      wb.alu_rd    = rd;
      wb.alu_data  = data;
      #1;
      check("alu_ready_single", 64'(wb.alu_ready), 64'h1);
      if (rd != '0) exp_q.push_back({rd, data});
      tick;
      wb.alu_valid = 1'b0;
   endtask

   task automatic lsu_write(input logic [AW-1:0] rd, input logic [DW-1:0] data);
      wb.lsu_valid = 1'b1;
      wb.lsu_rd    = rd;
      wb.lsu_data  = data;
      #1;
      check("lsu_ready_single", 64'(wb.lsu_ready), 64'h1);
      if (rd != '0) exp_q.push_back({rd, data});
      tick;
      wb.lsu_valid = 1'b0;
   endtask

   always @(negedge clk) begin : monitor
      logic [AW+DW-1:0] e;
      if (wb.rf_wen === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write",
                     wb.rf_waddr, wb.rf_wdata);
         end else begin
            e = exp_q.pop_front();
            check("commit_addr", 64'(wb.rf_waddr), 64'(e[AW+DW-1:DW]));
            check("commit_data", 64'(wb.rf_wdata), 64'(e[DW-1:0]));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish expected finish before timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [AW-1:0] a_rd;
      logic [AW-1:0] l_rd;
      wb.alu_valid = 1'b0; wb.alu_rd = '0; wb.alu_data = '0;
      wb.lsu_valid = 1'b0; wb.lsu_rd = '0; wb.lsu_data = '0;
      wb.issue_valid = 1'b0; wb.issue_rd = '0;

      // Reset state
      repeat (2) tick;
      check("rst_wen",   64'(wb.rf_wen),   64'h0);
      check("rst_waddr", 64'(wb.rf_waddr), 64'h0);
      check("rst_wdata", 64'(wb.rf_wdata), 64'h0);
      check("rst_busy",  64'(wb.busy),     64'h0);
      check("rst_err",   64'(wb.err),      64'h0);
      rst_n = 1'b1;
      tick;

      // Single ALU write with latency and busy timing
      issue(5'd5);
      check("busy_after_issue", 64'(wb.busy), 64'h20);
      alu_write(5'd5, 32'hDEADBEEF);
      check("wen_cycle_n1",  64'(wb.rf_wen),  64'h1);
      check("busy5_cycle_n1", 64'(wb.busy[5]), 64'h1);
      tick;
      check("busy5_cycle_n2", 64'(wb.busy[5]), 64'h0);
      check("wen_cycle_n2",  64'(wb.rf_wen),  64'h0);
      check("err_after_x5",  64'(wb.err),     64'h0);

      // Both channels contending
      for (int i = 1; i <= 4; i++) issue(AW'(i));
      for (int i = 6; i <= 9; i++) issue(AW'(i));
      check("busy_tie_issued", 64'(wb.busy), 64'h3DE);
      a_rd = 5'd1;
      l_rd = 5'd6;
      for (int c = 0; c < 8; c++) begin
         wb.alu_valid = (a_rd <= 5'd4);
         wb.alu_rd    = a_rd;
         wb.alu_data  = 32'hA000 + 32'(a_rd);
         wb.lsu_valid = (l_rd <= 5'd9);
         wb.lsu_rd    = l_rd;
         wb.lsu_data  = 32'hB000 + 32'(l_rd);
         #1;
         check($sformatf("tie_alu_ready_c%0d", c), 64'(wb.alu_ready), 64'(alu_rdy_e[c]));
         check($sformatf("tie_lsu_ready_c%0d", c), 64'(wb.lsu_ready), 64'(lsu_rdy_e[c]));
         if (win_lsu[c]) begin
            exp_q.push_back({l_rd, 32'hB000 + 32'(l_rd)});
            l_rd = l_rd + 5'd1;
         end else begin
            exp_q.push_back({a_rd, 32'hA000 + 32'(a_rd)});
            a_rd = a_rd + 5'd1;
         end
         tick;
      end
      wb.alu_valid = 1'b0;
      wb.lsu_valid = 1'b0;
      tick;
      check("busy_tie_drained", 64'(wb.busy), 64'h0);
      check("err_tie",          64'(wb.err),  64'h0);

      // Write to x0 is consumed but never commits
      alu_write(5'd0, 32'h1234);
      check("x0_wen",  64'(wb.rf_wen), 64'h0);
      check("x0_busy", 64'(wb.busy),   64'h0);
      tick;
      check("x0_err",  64'(wb.err),    64'h0);

      // Commit and reissue of x3 on the same edge
      issue(5'd3);
      alu_write(5'd3, 32'h33);
      wb.issue_valid = 1'b1;
      wb.issue_rd    = 5'd3;
      tick;
      wb.issue_valid = 1'b0;
      check("x3_reissue_busy", 64'(wb.busy), 64'h8);
      check("x3_reissue_err",  64'(wb.err),  64'h0);
      alu_write(5'd3, 32'h34);
      tick;
      check("x3_final_busy", 64'(wb.busy), 64'h0);

      // Unissued commit raises sticky err
      lsu_write(5'd10, 32'hA0A0);
      check("err_before_commit", 64'(wb.err), 64'h0);
      tick;
      check("err_at_commit", 64'(wb.err), 64'h1);
      repeat (2) tick;
      check("err_sticky", 64'(wb.err), 64'h1);

      // Reset right after an accept drops the pending state
      issue(5'd12);
      alu_write(5'd12, 32'hC0DE);
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      check("post_rst_wen",  64'(wb.rf_wen), 64'h0);
      check("post_rst_busy", 64'(wb.busy),   64'h0);
      check("post_rst_err",  64'(wb.err),    64'h0);
      wb.alu_valid = 1'b1; wb.alu_rd = 5'd0; wb.alu_data = 32'h1;
      wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd0; wb.lsu_data = 32'h2;
      #1;
      check("post_rst_tie_lsu", 64'(wb.lsu_ready), 64'h1);
      check("post_rst_tie_alu", 64'(wb.alu_ready), 64'h0);
      tick;
      wb.alu_valid = 1'b0;
      wb.lsu_valid = 1'b0;
      check("post_rst_tie_wen", 64'(wb.rf_wen), 64'h0);

      repeat (2) tick;
      check("queue_drained", 64'(exp_q.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
